// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encodings and debounce defaults for the stopwatch controller
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_LAP    = 2'b11
  } state_t;

  // 10 ms of stable level at 50 MHz
  localparam int DB_CYCLES_DEF = 500000;
  localparam int DB_W_DEF      = 19;

endpackage

// File: rtl/btn_cond.sv
// rtl/btn_cond.sv - push-button synchroniser, debouncer and press-edge detector
module btn_cond
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int DB_W      = DB_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  logic            sync0;
  logic            sync1;
  logic [DB_W-1:0] cnt;
  logic            settle;

  // Synced level has disagreed with the debounced level long enough to be accepted
  assign settle = (sync1 != btn_level) && (cnt == DB_W'(DB_CYCLES - 1));

  // The debounced level comes out of reset as "pressed": a button still held across
  // reset release never produces a rising edge, and a released one settles to 0
  // silently. The sync pipeline refills in two cycles, so DB_CYCLES must exceed 2.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync0     <= 1'b0;
      sync1     <= 1'b0;
      cnt       <= '0;
      btn_level <= 1'b1;
      btn_press <= 1'b0;
    end else begin
      sync0     <= btn_raw;
      sync1     <= sync0;
      btn_press <= settle && sync1;
      if (sync1 == btn_level) begin
        cnt <= '0;
      end else if (settle) begin
        cnt       <= '0;
        btn_level <= sync1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/lap/clear sequencer for the 4-digit stopwatch
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int DB_W      = DB_W_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       tick,
  output logic       count_en,
  output logic       clr_cnt,
  output logic       disp_hold,
  output logic [1:0] state
);

  state_t state_q;
  state_t state_n;
  logic   clr_n;
  logic   hold_n;
  logic   ss_press;
  logic   lap_press;

  btn_cond #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_ss (
    .clock     (clock),
    .reset     (reset),
    .btn_raw   (start_stop),
    .btn_level (),
    .btn_press (ss_press)
  );

  btn_cond #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_lap (
    .clock     (clock),
    .reset     (reset),
    .btn_raw   (lap),
    .btn_level (),
    .btn_press (lap_press)
  );

  // Next state from press pulses; start/stop takes priority over a same-cycle lap
  always_comb begin
    state_n = state_q;
    clr_n   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_press) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (ss_press)       state_n = ST_PAUSED;
        else if (lap_press) state_n = ST_LAP;
      end
      ST_LAP: begin
        if (ss_press)       state_n = ST_PAUSED;
        else if (lap_press) state_n = ST_RUN;
      end
      ST_PAUSED: begin
        if (ss_press) begin
          state_n = ST_RUN;
        end else if (lap_press) begin
          state_n = ST_IDLE;
          clr_n   = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    hold_n = (state_n == ST_LAP);
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      clr_cnt   <= 1'b0;
      disp_hold <= 1'b0;
    end else begin
      state_q   <= state_n;
      clr_cnt   <= clr_n;
      disp_hold <= hold_n;
    end
  end

  // Counting continues through LAP; only the display is frozen there
  assign count_en = tick && ((state_q == ST_RUN) || (state_q == ST_LAP));
  assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed scoreboard bench for stopwatch_ctrl
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_stop = 1'b0;
  logic       lap = 1'b0;
  logic       tick = 1'b0;
  logic       count_en;
  logic       clr_cnt;
  logic       disp_hold;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int tick_n = 0;
  int en_n = 0;
  logic       mon_on = 1'b0;
  logic [1:0] m_st = 2'b00;
  logic       m_clr = 1'b0;

  typedef struct packed {
    logic [1:0] st;
    logic       hold;
    logic       clr;
  } exp_t;

  exp_t sb[$];

  stopwatch_ctrl #(.DB_CYCLES(4), .DB_W(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_stop (start_stop),
    .lap        (lap),
    .tick       (tick),
    .count_en   (count_en),
    .clr_cnt    (clr_cnt),
    .disp_hold  (disp_hold),
    .state      (state)
  );

  always #5 clock = ~clock;

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One-cycle tick every 10 clocks
  initial begin
    forever begin
      repeat (9) @(posedge clock);
      #1 tick = 1'b1;
      @(posedge clock);
      #1 tick = 1'b0;
    end
  end

  // Per-cycle output model driven by the bench's own expected state
  initial begin
    forever begin
      @(negedge clock);
      if (mon_on) begin
        check1("mon_state", {30'd0, state}, {30'd0, m_st});
        check1("mon_count_en", {31'd0, count_en},
               {31'd0, tick && (m_st == ST_RUN || m_st == ST_LAP)});
        check1("mon_disp_hold", {31'd0, disp_hold}, {31'd0, m_st == ST_LAP});
        check1("mon_clr_cnt", {31'd0, clr_cnt}, {31'd0, m_clr});
        if (tick) tick_n++;
        if (count_en) en_n++;
      end
    end
  end

  // Raise the chosen buttons (optionally bouncing), expect the transition exactly
  // 7 cycles after the steady rise, then release after `hold` cycles.
  task automatic press(input logic do_ss, input logic do_lap, input logic bounce,
                       input exp_t e, input int hold);
    exp_t got;
    sb.push_back(e);
    if (bounce) begin
      for (int i = 0; i < 4; i++) begin
        if (do_ss)  start_stop = ~i[0];
        if (do_lap) lap = ~i[0];
        step();
      end
    end
    if (do_ss)  start_stop = 1'b1;
    if (do_lap) lap = 1'b1;
    repeat (6) step();
    check1("pre_latency_state", {30'd0, state}, {30'd0, m_st});
    step();
    got = sb.pop_front();
    m_st = got.st;
    m_clr = got.clr;
    check1("sb_state", {30'd0, state}, {30'd0, got.st});
    check1("sb_disp_hold", {31'd0, disp_hold}, {31'd0, got.hold});
    check1("sb_clr_cnt", {31'd0, clr_cnt}, {31'd0, got.clr});
    step();
    m_clr = 1'b0;
    check1("clr_one_cycle", {31'd0, clr_cnt}, 32'd0);
    repeat (hold - 8) step();
    if (do_ss)  start_stop = 1'b0;
    if (do_lap) lap = 1'b0;
    repeat (10) step();
  endtask

  initial begin
    // 1. reset and idle ticks
    reset = 1'b0;
    repeat (3) step();
    check1("rst_state", {30'd0, state}, 32'd0);
    check1("rst_count_en", {31'd0, count_en}, 32'd0);
    check1("rst_disp_hold", {31'd0, disp_hold}, 32'd0);
    check1("rst_clr_cnt", {31'd0, clr_cnt}, 32'd0);
    reset = 1'b1;
    m_st = ST_IDLE;
    mon_on = 1'b1;
    tick_n = 0;
    en_n = 0;
    repeat (500) step();
    check1("idle_ticks_seen", tick_n, 32'd50);
    check1("idle_no_count_en", en_n, 32'd0);

    // 2. start
    press(1'b1, 1'b0, 1'b0, '{ST_RUN, 1'b0, 1'b0}, 20);
    tick_n = 0;
    en_n = 0;
    repeat (100) step();
    check1("run_no_tick_lost", en_n, tick_n);
    check1("run_count_en_n", en_n, 32'd10);

    // 3. bouncing lap, then lap back to run
    press(1'b0, 1'b1, 1'b1, '{ST_LAP, 1'b1, 1'b0}, 20);
    tick_n = 0;
    en_n = 0;
    repeat (50) step();
    check1("lap_counting", en_n, 32'd5);
    press(1'b0, 1'b1, 1'b0, '{ST_RUN, 1'b0, 1'b0}, 20);

    // 4. pause, clear to idle, restart
    press(1'b1, 1'b0, 1'b0, '{ST_PAUSED, 1'b0, 1'b0}, 20);
    tick_n = 0;
    en_n = 0;
    repeat (50) step();
    check1("paused_ticks_seen", tick_n, 32'd5);
    check1("paused_no_count_en", en_n, 32'd0);
    press(1'b0, 1'b1, 1'b0, '{ST_IDLE, 1'b0, 1'b1}, 20);
    press(1'b1, 1'b0, 1'b0, '{ST_RUN, 1'b0, 1'b0}, 20);

    // 5. simultaneous presses in RUN: start/stop wins
    press(1'b1, 1'b1, 1'b0, '{ST_PAUSED, 1'b0, 1'b0}, 20);

    // 6. reset in LAP with start/stop held
    press(1'b1, 1'b0, 1'b0, '{ST_RUN, 1'b0, 1'b0}, 20);
    press(1'b0, 1'b1, 1'b0, '{ST_LAP, 1'b1, 1'b0}, 20);
    start_stop = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    m_st = ST_IDLE;
    check1("lap_rst_state", {30'd0, state}, 32'd0);
    check1("lap_rst_disp_hold", {31'd0, disp_hold}, 32'd0);
    repeat (30) step();
    check1("held_no_run", {30'd0, state}, 32'd0);
    start_stop = 1'b0;
    repeat (15) step();
    press(1'b1, 1'b0, 1'b0, '{ST_RUN, 1'b0, 1'b0}, 20);

    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
